// File: rtl/hdlc_rx_channel.sv
// HDLC serial receive front end: flag/abort detection, zero de-stuffing,
// LSB-first byte assembly and frame delimiting toward the Rx buffer and FCS logic.
module hdlc_rx_channel #(
    parameter int MAX_BYTES = 128
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               Rx,
    input  logic                               RxEN,
    output logic [7:0]                         Rx_Data,
    output logic                               Rx_NewByte,
    output logic                               Rx_FlagDetect,
    output logic                               Rx_AbortDetect,
    output logic                               Rx_ValidFrame,
    output logic                               Rx_StartZeroDetect,
    output logic                               Rx_EoF,
    output logic                               Rx_FrameError,
    output logic                               Rx_AbortSignal,
    output logic [$clog2(MAX_BYTES+1)-1:0]     Rx_FrameSize
);

    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] BYTE_MAX = CW'(MAX_BYTES);
    localparam logic [CW-1:0] BYTE_ONE = CW'(1);
    localparam logic [CW-1:0] BYTE_TWO = CW'(2);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    localparam logic [7:0] FLAG_PAT  = 8'h7E;
    // Oldest bit sits in window[0]: a 0 followed by seven 1s reads as 8'hFE.
    localparam logic [7:0] ABORT_PAT = 8'hFE;

    logic          rxd;
    logic [7:0]    window;
    logic [3:0]    skip;
    logic [2:0]    ones;
    logic [0:0]    state;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] byte_cnt;
    logic [6:0]    shreg;
    logic          reopen;

    logic [7:0]    window_next;
    logic          data_bit;
    logic          flag_hit;
    logic          abort_hit;

    always_comb begin
        window_next = {rxd, window[7:1]};
        data_bit    = window[0];
        flag_hit    = (window_next == FLAG_PAT);
        abort_hit   = (window_next == ABORT_PAT);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rxd                <= 1'b1;
            window             <= 8'hFF;
            skip               <= 4'd8;
            ones               <= 3'd0;
            state              <= ST_IDLE;
            bit_cnt            <= 3'd0;
            byte_cnt           <= '0;
            shreg              <= 7'd0;
            reopen             <= 1'b0;
            Rx_Data            <= 8'd0;
            Rx_NewByte         <= 1'b0;
            Rx_FlagDetect      <= 1'b0;
            Rx_AbortDetect     <= 1'b0;
            Rx_ValidFrame      <= 1'b0;
            Rx_StartZeroDetect <= 1'b0;
            Rx_EoF             <= 1'b0;
            Rx_FrameError      <= 1'b0;
            Rx_AbortSignal     <= 1'b0;
            Rx_FrameSize       <= '0;
        end else begin
            rxd                <= Rx;
            Rx_NewByte         <= 1'b0;
            Rx_FlagDetect      <= 1'b0;
            Rx_AbortDetect     <= 1'b0;
            Rx_StartZeroDetect <= 1'b0;
            Rx_EoF             <= 1'b0;
            Rx_AbortSignal     <= 1'b0;

            if (!RxEN) begin
                // Disabled: drop any open frame silently, keep last data/size.
                window        <= 8'hFF;
                skip          <= 4'd8;
                state         <= ST_IDLE;
                Rx_ValidFrame <= 1'b0;
                reopen        <= 1'b0;
                ones          <= 3'd0;
                bit_cnt       <= 3'd0;
                byte_cnt      <= '0;
            end else begin
                window         <= window_next;
                Rx_FlagDetect  <= flag_hit;
                Rx_AbortDetect <= abort_hit;

                // Pattern bits are still in the window; discard them as they leave.
                if (flag_hit || abort_hit) begin
                    skip <= 4'd8;
                end else if (skip != 4'd0) begin
                    skip <= skip - 4'd1;
                end

                if (reopen) begin
                    Rx_ValidFrame <= 1'b1;
                    reopen        <= 1'b0;
                end

                if (state == ST_FRAME && Rx_FlagDetect) begin
                    if (bit_cnt != 3'd0 || byte_cnt != '0) begin
                        Rx_EoF        <= 1'b1;
                        Rx_ValidFrame <= 1'b0;
                        reopen        <= 1'b1;
                        Rx_FrameSize  <= byte_cnt;
                        Rx_FrameError <= (bit_cnt != 3'd0) || (byte_cnt < BYTE_TWO);
                    end
                    bit_cnt  <= 3'd0;
                    byte_cnt <= '0;
                    ones     <= 3'd0;
                end else if (state == ST_FRAME && Rx_AbortDetect) begin
                    state          <= ST_IDLE;
                    Rx_ValidFrame  <= 1'b0;
                    Rx_AbortSignal <= 1'b1;
                    reopen         <= 1'b0;
                    bit_cnt        <= 3'd0;
                    byte_cnt       <= '0;
                    ones           <= 3'd0;
                end else if (state == ST_IDLE && Rx_FlagDetect) begin
                    state         <= ST_FRAME;
                    Rx_ValidFrame <= 1'b1;
                    Rx_FrameError <= 1'b0;
                    bit_cnt       <= 3'd0;
                    byte_cnt      <= '0;
                    ones          <= 3'd0;
                end else if (state == ST_FRAME && skip == 4'd0) begin
                    if (!data_bit && ones == 3'd5) begin
                        Rx_StartZeroDetect <= 1'b1;
                        ones               <= 3'd0;
                    end else begin
                        if (!data_bit) begin
                            ones <= 3'd0;
                        end else if (ones != 3'd5) begin
                            ones <= ones + 3'd1;
                        end
                        shreg   <= {data_bit, shreg[6:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            Rx_Data    <= {data_bit, shreg};
                            Rx_NewByte <= 1'b1;
                            if (byte_cnt != BYTE_MAX) begin
                                byte_cnt <= byte_cnt + BYTE_ONE;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hdlc_rx_channel.sv
// Directed bench for hdlc_rx_channel: table of bit streams with hand-computed
// results, plus hand-written timing, abort, enable and async-reset sequences.
module tb_hdlc_rx_channel;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic       RxEN;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_ValidFrame;
    logic       Rx_StartZeroDetect;
    logic       Rx_EoF;
    logic       Rx_FrameError;
    logic       Rx_AbortSignal;
    logic [7:0] Rx_FrameSize;

    hdlc_rx_channel #(.MAX_BYTES(128)) dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .Rx                 (Rx),
        .RxEN               (RxEN),
        .Rx_Data            (Rx_Data),
        .Rx_NewByte         (Rx_NewByte),
        .Rx_FlagDetect      (Rx_FlagDetect),
        .Rx_AbortDetect     (Rx_AbortDetect),
        .Rx_ValidFrame      (Rx_ValidFrame),
        .Rx_StartZeroDetect (Rx_StartZeroDetect),
        .Rx_EoF             (Rx_EoF),
        .Rx_FrameError      (Rx_FrameError),
        .Rx_AbortSignal     (Rx_AbortSignal),
        .Rx_FrameSize       (Rx_FrameSize)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    int c_nb, c_flag, c_abd, c_szd, c_eof, c_abs, c_valid;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge Clk) begin
        if (Rx_NewByte) begin
            c_nb++;
            got_q.push_back(Rx_Data);
        end
        if (Rx_FlagDetect)      c_flag++;
        if (Rx_AbortDetect)     c_abd++;
        if (Rx_StartZeroDetect) c_szd++;
        if (Rx_EoF)             c_eof++;
        if (Rx_AbortSignal)     c_abs++;
        if (Rx_ValidFrame)      c_valid++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        c_nb = 0; c_flag = 0; c_abd = 0; c_szd = 0; c_eof = 0; c_abs = 0; c_valid = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        RxEN = 1'b1;
        Rx   = 1'b1;
        Rst  = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_stream(input logic [63:0] bits, input int len);
        for (int i = 0; i < len; i++) send_bit(bits[len-1-i]);
    endtask

    typedef struct {
        string       name;
        logic [63:0] bits;
        int          len;
        int          n_bytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          flags;
        int          abd;
        int          abs;
        int          szd;
        int          eof;
        logic [7:0]  size;
        logic        err;
        logic        valid_end;
    } vec_t;

    vec_t vecs[5];

    initial begin
        // Streams are written in line order, leftmost bit first on the wire.
        vecs[0] = '{"a5_3c", 64'(32'b01111110_10100101_00111100_01111110), 32,
                    2, 8'hA5, 8'h3C, 2, 0, 0, 0, 1, 8'd2, 1'b0, 1'b1};
        vecs[1] = '{"stuffed", 64'(34'b01111110_111110111_011111010_01111110), 34,
                    2, 8'hFF, 8'h7E, 2, 0, 0, 2, 1, 8'd2, 1'b0, 1'b1};
        vecs[2] = '{"abort", 64'(24'b01111110_10101010_01111111), 24,
                    1, 8'h55, 8'h00, 1, 1, 1, 0, 0, 8'd0, 1'b0, 1'b0};
        vecs[3] = '{"short", 64'(27'b01111110_01001000_101_01111110), 27,
                    1, 8'h12, 8'h00, 2, 0, 0, 0, 1, 8'd1, 1'b1, 1'b1};
        vecs[4] = '{"flags3", 64'(42'b01111110_01111110_01111110_01001000_1101101101), 42,
                    1, 8'h12, 8'h00, 3, 0, 0, 0, 0, 8'd0, 1'b0, 1'b1};

        do_reset();
        chk("rst_data", Rx_Data, 8'h00);
        chk("rst_size", Rx_FrameSize, 8'h00);
        chk("rst_valid", Rx_ValidFrame, 1'b0);
        chk("rst_err", Rx_FrameError, 1'b0);
        chk("rst_pulses", {Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
                           Rx_StartZeroDetect, Rx_EoF, Rx_AbortSignal}, 6'd0);

        // Idle line
        clear_mon();
        repeat (100) send_bit(1'b1);
        chk("idle_pulses", c_nb + c_flag + c_abd + c_szd + c_eof + c_abs, 0);
        chk("idle_valid", c_valid, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            clear_mon();
            send_stream(vecs[v].bits, vecs[v].len);
            repeat (4) send_bit(1'b1);
            if (vecs[v].n_bytes > 0) exp_q.push_back(vecs[v].b0);
            if (vecs[v].n_bytes > 1) exp_q.push_back(vecs[v].b1);
            chk({vecs[v].name, "_nbytes"}, got_q.size(), vecs[v].n_bytes);
            while (exp_q.size() > 0 && got_q.size() > 0)
                chk({vecs[v].name, "_byte"}, got_q.pop_front(), exp_q.pop_front());
            chk({vecs[v].name, "_flags"}, c_flag, vecs[v].flags);
            chk({vecs[v].name, "_abortdet"}, c_abd, vecs[v].abd);
            chk({vecs[v].name, "_abortsig"}, c_abs, vecs[v].abs);
            chk({vecs[v].name, "_szd"}, c_szd, vecs[v].szd);
            chk({vecs[v].name, "_eof"}, c_eof, vecs[v].eof);
            chk({vecs[v].name, "_size"}, Rx_FrameSize, vecs[v].size);
            chk({vecs[v].name, "_err"}, Rx_FrameError, vecs[v].err);
            chk({vecs[v].name, "_valid"}, Rx_ValidFrame, vecs[v].valid_end);
        end

        // Flag latency: closing 0 sampled at edge t, detect visible after t+1
        do_reset();
        send_stream(64'(7'b0111111), 7);
        Rx = 1'b0;
        @(posedge Clk); #1;
        chk("flag_t0", Rx_FlagDetect, 1'b0);
        @(posedge Clk); #1;
        chk("flag_t1", Rx_FlagDetect, 1'b1);
        chk("flag_t1_valid", Rx_ValidFrame, 1'b0);
        @(posedge Clk); #1;
        chk("flag_t2", Rx_FlagDetect, 1'b0);
        chk("flag_t2_valid", Rx_ValidFrame, 1'b1);

        // Abort latency inside the open frame
        send_bit(1'b0);
        repeat (6) send_bit(1'b1);
        Rx = 1'b1;
        @(posedge Clk); #1;
        chk("abort_t0", Rx_AbortDetect, 1'b0);
        @(posedge Clk); #1;
        chk("abort_t1_det", Rx_AbortDetect, 1'b1);
        chk("abort_t1_sig", Rx_AbortSignal, 1'b0);
        chk("abort_t1_valid", Rx_ValidFrame, 1'b1);
        @(posedge Clk); #1;
        chk("abort_t2_sig", Rx_AbortSignal, 1'b1);
        chk("abort_t2_valid", Rx_ValidFrame, 1'b0);
        chk("abort_t2_det", Rx_AbortDetect, 1'b0);

        // Enable dropped mid-frame
        do_reset();
        send_stream(vecs[4].bits, vecs[4].len);
        repeat (4) send_bit(1'b1);
        chk("en_pre_valid", Rx_ValidFrame, 1'b1);
        chk("en_pre_data", Rx_Data, 8'h12);
        RxEN = 1'b0;
        @(posedge Clk); #1;
        chk("en_off_valid", Rx_ValidFrame, 1'b0);
        clear_mon();
        send_stream(64'(10'b01111110_00), 10);
        chk("en_off_flags", c_flag, 0);
        chk("en_off_eof_abort", c_eof + c_abs, 0);
        chk("en_off_valid_cnt", c_valid, 0);
        chk("en_off_data_hold", Rx_Data, 8'h12);

        // Re-enable, open a frame, then async reset between edges
        RxEN = 1'b1;
        send_stream(64'(11'b01111110_101), 11);
        chk("reen_valid", Rx_ValidFrame, 1'b1);
        #3 Rst = 1'b0;
        #1;
        chk("async_valid", Rx_ValidFrame, 1'b0);
        chk("async_data", Rx_Data, 8'h00);
        chk("async_size", Rx_FrameSize, 8'h00);
        chk("async_pulses", {Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
                             Rx_StartZeroDetect, Rx_EoF, Rx_AbortSignal, Rx_FrameError}, 7'd0);
        @(posedge Clk); #1 Rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
